// File: rtl/dpa_gadget_scheduler.sv
// Round-robin scheduler placing two requesters onto one shared masked gadget array (DOM AND/OR, XOR).
// Optional build macro DPA_SCHED_SHARE_CLEAR_EN: zero the gadget inputs for one cycle after each response.
module dpa_gadget_scheduler #(
    parameter int REGISTER_WIDTH   = 32,
    parameter int NUMBER_OF_SHARES = 3,
    parameter int GADGET_LATENCY   = 1,
    localparam int SW = REGISTER_WIDTH * NUMBER_OF_SHARES,
    localparam int RW = REGISTER_WIDTH * NUMBER_OF_SHARES * (NUMBER_OF_SHARES - 1) / 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][1:0]      req_op,
    input  logic [1:0][SW-1:0]   req_x,
    input  logic [1:0][SW-1:0]   req_y,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [RW-1:0]        rnd_data,
    output logic [1:0]           gadget_op,
    output logic [SW-1:0]        gadget_x,
    output logic [SW-1:0]        gadget_y,
    output logic [RW-1:0]        gadget_r,
    input  logic [SW-1:0]        gadget_s,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic                 resp_err,
    output logic [SW-1:0]        resp_s,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam int CW = $clog2(GADGET_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(GADGET_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_RESP  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t          state_q;
    logic            last_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      gadget_op_q;
    logic [SW-1:0]   gadget_x_q;
    logic [SW-1:0]   gadget_y_q;
    logic [RW-1:0]   gadget_r_q;
    logic            resp_valid_q;
    logic            resp_id_q;
    logic            resp_err_q;
    logic [SW-1:0]   resp_s_q;

    logic [1:0]      nonlinear;
    logic [1:0]      eligible;
    logic            win_id;
    logic            grant;
    logic [1:0]      win_op;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // req_ready/rnd_ready are combinational grants, resp_valid is held until resp_ready.
    assign nonlinear[0] = (req_op[0] == OP_AND) || (req_op[0] == OP_OR);
    assign nonlinear[1] = (req_op[1] == OP_AND) || (req_op[1] == OP_OR);
    assign eligible[0]  = req_valid[0] && (!nonlinear[0] || rnd_valid);
    assign eligible[1]  = req_valid[1] && (!nonlinear[1] || rnd_valid);

    // On a tie the requester that did not win last time goes first.
    assign win_id = (eligible == 2'b11) ? ~last_q : eligible[1];
    assign grant  = (state_q == ST_IDLE) && (|eligible);
    assign win_op = req_op[win_id];

    assign req_ready = grant ? (win_id ? 2'b10 : 2'b01) : 2'b00;
    assign rnd_ready = grant && nonlinear[win_id];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            gadget_op_q  <= '0;
            gadget_x_q   <= '0;
            gadget_y_q   <= '0;
            gadget_r_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_s_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        last_q    <= win_id;
                        resp_id_q <= win_id;
                        cnt_q     <= '0;
                        if (win_op == OP_RSV) begin
                            // Reserved opcodes never touch the gadget or the randomness source.
                            resp_err_q   <= 1'b1;
                            resp_s_q     <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            gadget_op_q <= win_op;
                            gadget_x_q  <= req_x[win_id];
                            gadget_y_q  <= req_y[win_id];
                            gadget_r_q  <= nonlinear[win_id] ? rnd_data : '0;
                            resp_err_q  <= 1'b0;
                            state_q     <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == CNT_LAST) begin
                        resp_s_q     <= gadget_s;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
`ifdef DPA_SCHED_SHARE_CLEAR_EN
                        gadget_op_q <= '0;
                        gadget_x_q  <= '0;
                        gadget_y_q  <= '0;
                        gadget_r_q  <= '0;
                        state_q     <= ST_CLEAR;
`else
                        state_q     <= ST_IDLE;
`endif
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gadget_op  = gadget_op_q;
    assign gadget_x   = gadget_x_q;
    assign gadget_y   = gadget_y_q;
    assign gadget_r   = gadget_r_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;
    assign resp_s     = resp_s_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dpa_gadget_scheduler.sv
// Bench for dpa_gadget_scheduler: DOM gadget model, randomized requesters, scoreboard with expected queue.
module tb_dpa_gadget_scheduler;

    localparam int W   = 32;
    localparam int N   = 3;
    localparam int L   = 1;
    localparam int SW  = W * N;
    localparam int RW  = W * N * (N - 1) / 2;
    localparam int RPB = RW / W;
`ifdef DPA_SCHED_SHARE_CLEAR_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 1;
`endif

    logic                clock;
    logic                reset_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0][1:0]     req_op;
    logic [1:0][SW-1:0]  req_x;
    logic [1:0][SW-1:0]  req_y;
    logic                rnd_valid;
    logic                rnd_ready;
    logic [RW-1:0]       rnd_data;
    logic [1:0]          gadget_op;
    logic [SW-1:0]       gadget_x;
    logic [SW-1:0]       gadget_y;
    logic [RW-1:0]       gadget_r;
    logic [SW-1:0]       gadget_s;
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_id;
    logic                resp_err;
    logic [SW-1:0]       resp_s;
    logic [1:0]          dbg_state;

    dpa_gadget_scheduler #(
        .REGISTER_WIDTH(W), .NUMBER_OF_SHARES(N), .GADGET_LATENCY(L)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .gadget_op(gadget_op), .gadget_x(gadget_x), .gadget_y(gadget_y),
        .gadget_r(gadget_r), .gadget_s(gadget_s),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_err(resp_err), .resp_s(resp_s), .dbg_state(dbg_state)
    );

    typedef struct {
        logic          id;
        logic [1:0]    op;
        logic [31:0]   xv;
        logic [31:0]   yv;
        logic [SW-1:0] x;
        logic [SW-1:0] y;
    } txn_t;

    typedef struct {
        logic          id;
        logic          err;
        logic [31:0]   val;
        logic [1:0]    gop;
        logic [SW-1:0] gx;
        logic [SW-1:0] gy;
        logic [RW-1:0] gr;
        int            acc_cyc;
        int            lat;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    txn_t pend_q[$];
    txn_t cur[2];
    logic cur_v[2];
    logic accepted[2];
    exp_t exp_q[$];
    int   grant_log[$];
    int   rnd_pulses = 0;
    int   rnd_mode  = 1;
    int   resp_mode = 1;

    // Reference model state: busy flag, earliest next accept, round-robin memory, last gadget load.
    logic          m_busy      = 1'b0;
    int            m_next_free = 0;
    logic          m_last      = 1'b1;
    logic [1:0]    m_gop       = '0;
    logic [SW-1:0] m_gx        = '0;
    logic [SW-1:0] m_gy        = '0;
    logic [RW-1:0] m_gr        = '0;

    logic [SW-1:0] gpipe[L];

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [SW-1:0] share_out(input logic [31:0] v);
        logic [SW-1:0] s;
        logic          acc;
        s = '0;
        for (int b = 0; b < W; b++) begin
            acc = 1'b0;
            for (int k = 0; k < N - 1; k++) begin
                s[b*N+k] = 1'($urandom_range(0, 1));
                acc      = acc ^ s[b*N+k];
            end
            s[b*N+N-1] = v[b] ^ acc;
        end
        return s;
    endfunction

    function automatic logic [31:0] recombine(input logic [SW-1:0] s);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < W; b++)
            for (int k = 0; k < N; k++)
                v[b] = v[b] ^ s[b*N+k];
        return v;
    endfunction

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    // Domain-oriented masking: share i gets x_i*y_i plus cross terms x_i*y_j blinded by r_{ij}.
    function automatic logic [SW-1:0] dom_gadget(input logic [1:0] op, input logic [SW-1:0] x,
                                                 input logic [SW-1:0] y, input logic [RW-1:0] r);
        logic [SW-1:0] z;
        logic [N-1:0]  a, bb, c;
        int            lo, hi, p;
        z = '0;
        for (int k = 0; k < W; k++) begin
            for (int s = 0; s < N; s++) begin
                a[s]  = x[k*N+s];
                bb[s] = y[k*N+s];
            end
            if (op == 2'b10) begin
                c = a ^ bb;
            end else if (op == 2'b11) begin
                c = '0;
            end else begin
                if (op == 2'b01) begin
                    a[0]  = ~a[0];
                    bb[0] = ~bb[0];
                end
                for (int i = 0; i < N; i++) begin
                    c[i] = a[i] & bb[i];
                    for (int j = 0; j < N; j++) begin
                        if (j != i) begin
                            lo = (i < j) ? i : j;
                            hi = (i < j) ? j : i;
                            p  = lo * N - lo * (lo + 1) / 2 + hi - lo - 1;
                            c[i] = c[i] ^ (a[i] & bb[j]) ^ r[k*RPB+p];
                        end
                    end
                end
                if (op == 2'b01) c[0] = ~c[0];
            end
            for (int s = 0; s < N; s++) z[k*N+s] = c[s];
        end
        return z;
    endfunction

    function automatic logic [RW-1:0] rand_rw();
        logic [RW-1:0] v;
        for (int k = 0; k < RW; k++) v[k] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic add_txn(input logic id, input logic [1:0] op, input logic [31:0] xv, input logic [31:0] yv);
        txn_t t;
        t.id = id; t.op = op; t.xv = xv; t.yv = yv;
        t.x  = share_out(xv);
        t.y  = share_out(yv);
        pend_q.push_back(t);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"},  req_ready, 0);
        check({tag, "_rnd_ready"},  rnd_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_id"},    resp_id, 0);
        check({tag, "_resp_err"},   resp_err, 0);
        check({tag, "_resp_s"},     resp_s, 0);
        check({tag, "_gadget_op"},  gadget_op, 0);
        check({tag, "_gadget_x"},   gadget_x, 0);
        check({tag, "_gadget_y"},   gadget_y, 0);
        check({tag, "_gadget_r"},   gadget_r, 0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(pend_q.size() == 0 && !cur_v[0] && !cur_v[1] && exp_q.size() == 0 && !m_busy) && n < budget) begin
            @(posedge clock);
            n++;
        end
        check({name, "_drain_in_budget"}, n < budget, 1);
        repeat (2) @(posedge clock);
    endtask

    task automatic model_reset();
        pend_q.delete();
        exp_q.delete();
        cur_v[0] = 1'b0; cur_v[1] = 1'b0;
        accepted[0] = 1'b0; accepted[1] = 1'b0;
        m_busy = 1'b0; m_next_free = 0; m_last = 1'b1;
        m_gop = '0; m_gx = '0; m_gy = '0; m_gr = '0;
    endtask

    // ---------------- gadget array model ----------------
    always @(posedge clock) begin
        gpipe[0] <= dom_gadget(gadget_op, gadget_x, gadget_y, gadget_r);
        for (int k = 1; k < L; k++) gpipe[k] <= gpipe[k-1];
    end
    assign gadget_s = gpipe[L-1];

    // ---------------- driver ----------------
    always @(posedge clock) begin
        #1;
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (accepted[i]) begin
                    cur_v[i]    = 1'b0;
                    accepted[i] = 1'b0;
                end
                if (!cur_v[i]) begin
                    for (int k = 0; k < pend_q.size(); k++) begin
                        if (pend_q[k].id == 1'(i)) begin
                            cur[i]   = pend_q[k];
                            cur_v[i] = 1'b1;
                            pend_q.delete(k);
                            break;
                        end
                    end
                end
                req_valid[i] = cur_v[i];
                req_op[i]    = cur_v[i] ? cur[i].op : 2'b00;
                req_x[i]     = cur_v[i] ? cur[i].x : '0;
                req_y[i]     = cur_v[i] ? cur[i].y : '0;
            end
            rnd_valid  = (rnd_mode == 2) ? ($urandom_range(0, 3) != 0) : (rnd_mode == 1);
            rnd_data   = rand_rw();
            resp_ready = (resp_mode == 2) ? 1'($urandom_range(0, 1)) : (resp_mode == 1);
        end
    end

    // ---------------- arbitration model and accept recorder ----------------
    always @(negedge clock) begin
        logic [1:0] elig;
        logic [1:0] exp_ready;
        logic       exp_rnd;
        logic       free;
        logic       w;
        exp_t       e;
        txn_t       t;
        if (reset_n) begin
            for (int i = 0; i < 2; i++)
                elig[i] = req_valid[i] && (req_op[i] == 2'b10 || req_op[i] == 2'b11 || rnd_valid);
            free      = !m_busy && (cyc >= m_next_free);
            exp_ready = 2'b00;
            exp_rnd   = 1'b0;
            w         = 1'b0;
            if (free && elig != 2'b00) begin
                w         = (elig == 2'b11) ? !m_last : elig[1];
                exp_ready = w ? 2'b10 : 2'b01;
                exp_rnd   = (req_op[w] == 2'b00 || req_op[w] == 2'b01);
            end
            check("req_ready", req_ready, exp_ready);
            check("rnd_ready", rnd_ready, exp_rnd);
            if (rnd_ready) rnd_pulses++;
            if (req_ready == 2'b01) grant_log.push_back(0);
            if (req_ready == 2'b10) grant_log.push_back(1);
            if (exp_ready != 2'b00) begin
                t       = cur[w];
                e.id    = w;
                e.err   = (t.op == 2'b11);
                e.val   = ref_op(t.op, t.xv, t.yv);
                e.acc_cyc = cyc;
                e.lat   = e.err ? 1 : L + 2;
                if (!e.err) begin
                    m_gop = t.op;
                    m_gx  = t.x;
                    m_gy  = t.y;
                    m_gr  = exp_rnd ? rnd_data : '0;
                end
                e.gop = m_gop; e.gx = m_gx; e.gy = m_gy; e.gr = m_gr;
                exp_q.push_back(e);
                accepted[w] = 1'b1;
                m_busy      = 1'b1;
                m_last      = w;
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    always @(negedge clock) begin
        static logic          seen = 1'b0;
        static int            first_cyc = 0;
        static logic          prev_stall = 1'b0;
        static logic [SW-1:0] prev_s = '0;
        static logic          prev_id = 1'b0;
        static logic          prev_err = 1'b0;
        exp_t e;
        if (!reset_n) begin
            seen       = 1'b0;
            prev_stall = 1'b0;
        end else if (resp_valid) begin
            if (!seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_resp: resp_valid=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                if (prev_stall) begin
                    check("stall_resp_s", resp_s, prev_s);
                    check("stall_resp_id", resp_id, prev_id);
                    check("stall_resp_err", resp_err, prev_err);
                end
                if (resp_ready) begin
                    e = exp_q.pop_front();
                    check("resp_id", resp_id, e.id);
                    check("resp_err", resp_err, e.err);
                    if (e.err) check("resp_s_zero", resp_s, 0);
                    else       check("resp_value", recombine(resp_s), e.val);
                    check("resp_latency", first_cyc - e.acc_cyc, e.lat);
                    check("gadget_op", gadget_op, e.gop);
                    check("gadget_x", gadget_x, e.gx);
                    check("gadget_y", gadget_y, e.gy);
                    check("gadget_r", gadget_r, e.gr);
                    m_busy      = 1'b0;
                    m_next_free = cyc + GAP;
                    seen        = 1'b0;
`ifdef DPA_SCHED_SHARE_CLEAR_EN
                    m_gop = '0; m_gx = '0; m_gy = '0; m_gr = '0;
`endif
                end
            end
            prev_stall = !resp_ready;
            prev_s     = resp_s;
            prev_id    = resp_id;
            prev_err   = resp_err;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        reset_n    = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_x      = '0;
        req_y      = '0;
        rnd_valid  = 1'b0;
        rnd_data   = '0;
        resp_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        rnd_mode = 1;
        resp_mode = 1;

        // AND from requester 0
        @(posedge clock);
        add_txn(1'b0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00);
        wait_drain("and_req0", 50);

        // OR from requester 1, exactly one randomness word
        base = rnd_pulses;
        add_txn(1'b1, 2'b01, 32'h00000001, 32'h80000000);
        wait_drain("or_req1", 50);
        check("or_rnd_pulses", rnd_pulses - base, 1);

        // both requesters loaded: grants alternate
        grant_log.delete();
        add_txn(1'b0, 2'b00, $urandom(), $urandom());
        add_txn(1'b1, 2'b10, $urandom(), $urandom());
        add_txn(1'b0, 2'b01, $urandom(), $urandom());
        add_txn(1'b1, 2'b00, $urandom(), $urandom());
        wait_drain("alternate", 100);
        check("alt_grant_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++)
            check("alt_grant_order", grant_log[i], i % 2);

        // no randomness: XOR from requester 1 overtakes AND from requester 0
        rnd_mode = 0;
        @(posedge clock);
        grant_log.delete();
        base = rnd_pulses;
        add_txn(1'b0, 2'b00, 32'h12345678, 32'h0F0F0F0F);
        add_txn(1'b1, 2'b10, 32'hAAAA5555, 32'h0000FFFF);
        for (int n = 0; n < 50 && !(grant_log.size() >= 1 && !m_busy); n++) @(posedge clock);
        check("starved_first_grant_count", grant_log.size(), 1);
        if (grant_log.size() >= 1) check("starved_first_grant", grant_log[0], 1);
        check("starved_rnd_pulses", rnd_pulses - base, 0);
        repeat (4) @(posedge clock);
        check("starved_still_pending", cur_v[0], 1);
        rnd_mode = 1;
        wait_drain("starved_release", 50);

        // reserved opcode
        base = rnd_pulses;
        add_txn(1'b0, 2'b11, 32'hDEADBEEF, 32'h01234567);
        wait_drain("reserved", 50);
        check("reserved_rnd_pulses", rnd_pulses - base, 0);

        // response stall: no new accept while held
        resp_mode = 0;
        add_txn(1'b1, 2'b10, 32'h0000FFFF, 32'h00FF00FF);
        repeat (12) @(posedge clock);
        add_txn(1'b0, 2'b10, 32'h11111111, 32'h22222222);
        repeat (8) @(posedge clock);
        #2;
        check("stall_resp_valid", resp_valid, 1);
        check("stall_outstanding", exp_q.size(), 1);
        resp_mode = 1;
        wait_drain("stall_release", 50);

        // randomized traffic
        rnd_mode  = 2;
        resp_mode = 2;
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            add_txn(1'($urandom_range(0, 1)), (r == 0) ? 2'b11 : 2'(r % 3), $urandom(), $urandom());
        end
        wait_drain("random", 4000);

        // reset during EXEC
        rnd_mode  = 1;
        resp_mode = 1;
        add_txn(1'b1, 2'b00, 32'hCAFEF00D, 32'h8BADF00D);
        for (int n = 0; n < 20 && !m_busy; n++) @(posedge clock);
        check("reset_test_accepted", m_busy, 1);
        @(posedge clock);
        #2;
        reset_n   = 1'b0;
        req_valid = '0;
        model_reset();
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            check("post_reset_no_resp", resp_valid, 0);
        end
        grant_log.delete();
        add_txn(1'b1, 2'b10, 32'h0F0F0F0F, 32'h00FF00FF);
        add_txn(1'b0, 2'b10, 32'h13579BDF, 32'h2468ACE0);
        wait_drain("post_reset", 50);
        if (grant_log.size() >= 1) check("post_reset_favours_0", grant_log[0], 0);
        else check("post_reset_grant_seen", grant_log.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
